swizzle_vector_runner: RTL

Synthesizable stimulus-and-check engine for the bit-swizzling stage. It holds a small vector memory of {C, D, expected Y} words and drives C/D into the swizzling block one vector at a time. It compares the returned Y against the expected value and reports a pass/fail tally on chip. It sits directly upstream of the swizzling block: its C/D outputs feed that block, and its Y input is that block's result.

---
 rtl/swizzle_vector_runner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/swizzle_vector_runner.sv
// On-chip stimulus/check engine for the bit-swizzling stage: replays {C, D, Y_expected}
// vectors from a small memory and tallies mismatches against the returned Y.
module swizzle_vector_runner #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 9,
  parameter int unsigned DEPTH = 21,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned VEC_W = 2 * IN_W + OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW:0]      num_vectors,
  input  logic             vec_wr_en,
  input  logic [AW-1:0]    vec_wr_addr,
  input  logic [VEC_W-1:0] vec_wr_data,
  output logic [IN_W-1:0]  C,
  output logic [IN_W-1:0]  D,
  input  logic [OUT_W-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [31:0]      vectornum,
  output logic [31:0]      errors,
  output logic             first_err_valid,
  output logic [AW-1:0]    first_err_idx,
  output logic [OUT_W-1:0] first_err_y
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StApply = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [VEC_W-1:0] mem [DEPTH];

  logic [1:0]       state_q;
  logic [AW:0]      n_q;
  logic [AW-1:0]    idx_q;
  logic [IN_W-1:0]  c_q;
  logic [IN_W-1:0]  d_q;
  logic [OUT_W-1:0] exp_q;
  logic [31:0]      vectornum_q;
  logic [31:0]      errors_q;
  logic             fev_q;
  logic [AW-1:0]    fei_q;
  logic [OUT_W-1:0] fey_q;

  logic          wr_ok;
  logic [AW:0]   n_clamped;
  logic          mismatch;
  logic          last_vec;

  assign busy      = (state_q == StApply) || (state_q == StCheck);
  assign wr_ok     = vec_wr_en && !busy && ({1'b0, vec_wr_addr} < DepthW);
  assign n_clamped = (num_vectors > DepthW) ? DepthW : num_vectors;
  assign mismatch  = (Y != exp_q);
  assign last_vec  = (({1'b0, idx_q} + (AW + 1)'(1)) == n_q);

  // Vector memory is deliberately not reset so loaded vectors survive a reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[vec_wr_addr] <= vec_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      n_q         <= '0;
      idx_q       <= '0;
      c_q         <= '0;
      d_q         <= '0;
      exp_q       <= '0;
      vectornum_q <= '0;
      errors_q    <= '0;
      fev_q       <= 1'b0;
      fei_q       <= '0;
      fey_q       <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            n_q         <= n_clamped;
            idx_q       <= '0;
            vectornum_q <= '0;
            errors_q    <= '0;
            fev_q       <= 1'b0;
            fei_q       <= '0;
            fey_q       <= '0;
            state_q     <= (n_clamped == '0) ? StDone : StApply;
          end
        end
        StApply: begin
          {c_q, d_q, exp_q} <= mem[idx_q];
          state_q           <= StCheck;
        end
        StCheck: begin
          vectornum_q <= vectornum_q + 32'd1;
          if (mismatch) begin
            if (errors_q != '1) begin
              errors_q <= errors_q + 32'd1;
            end
            if (!fev_q) begin
              fev_q <= 1'b1;
              fei_q <= idx_q;
              fey_q <= Y;
            end
          end
          if (last_vec) begin
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + AW'(1);
            state_q <= StApply;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign C               = c_q;
  assign D               = d_q;
  assign done            = (state_q == StDone);
  assign vectornum       = vectornum_q;
  assign errors          = errors_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign first_err_y     = fey_q;

endmodule
